// File: rtl/vic_regs.sv
// VIC 6560/6561 register file: 16 CPU registers, raster counter, base-address decode.
// Optional VIC_FRAME_LATCH_EN: renderer-facing outputs update only on frame_tick.
module vic_regs #(
   parameter int RASTER_LINES = 312
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_cs,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   input  logic        line_tick,
   input  logic        frame_tick,
   output logic [15:0] screen_addr,
   output logic [15:0] char_rom_addr,
   output logic [15:0] color_ram_addr,
   output logic [2:0]  border_color,
   output logic [3:0]  back_color,
   output logic        inverted,
   output logic [3:0]  aux_color,
   output logic        chars8x16,
   output logic [6:0]  rows,
   output logic [6:0]  cols,
   output logic [8:0]  raster
);

   localparam logic [8:0] LAST_LINE = 9'(RASTER_LINES - 1);

   logic [7:0] r0, r1, r2, r5, ra, rb, rc, rd, re, rf;
   logic [6:0] r3;
   logic [7:0] sh2, sh5, shf;
   logic [6:0] sh3;
   logic [3:0] she;
   logic       load;
   logic       wr, rd_en;
   logic [7:0] rd_val;
   logic [13:0] scr_v, chr_v;

   assign wr    = cpu_cs & cpu_we;
   assign rd_en = cpu_cs & ~cpu_we;

   // Reg3 bit7 and reg4 are raster readback; 6-9 are fixed read-only values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0 <= 8'h0C; r1 <= 8'h26; r2 <= 8'h96; r3 <= 7'h2E; r5 <= 8'hF0;
         ra <= 8'h00; rb <= 8'h00; rc <= 8'h00; rd <= 8'h00;
         re <= 8'h00; rf <= 8'h1B;
      end else if (wr) begin
         case (cpu_addr)
            4'h0: r0 <= cpu_din;
            4'h1: r1 <= cpu_din;
            4'h2: r2 <= cpu_din;
            4'h3: r3 <= cpu_din[6:0];
            4'h5: r5 <= cpu_din;
            4'hA: ra <= cpu_din;
            4'hB: rb <= cpu_din;
            4'hC: rc <= cpu_din;
            4'hD: rd <= cpu_din;
            4'hE: re <= cpu_din;
            4'hF: rf <= cpu_din;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_val = 8'h00;
      case (cpu_addr)
         4'h0: rd_val = r0;
         4'h1: rd_val = r1;
         4'h2: rd_val = r2;
         4'h3: rd_val = {raster[0], r3};
         4'h4: rd_val = raster[8:1];
         4'h5: rd_val = r5;
         4'h6, 4'h7: rd_val = 8'h00;
         4'h8, 4'h9: rd_val = 8'hFF;
         4'hA: rd_val = ra;
         4'hB: rd_val = rb;
         4'hC: rd_val = rc;
         4'hD: rd_val = rd;
         4'hE: rd_val = re;
         4'hF: rd_val = rf;
         default: rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   cpu_dout <= 8'h00;
      else if (rd_en) cpu_dout <= rd_val;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         raster <= '0;
      else if (frame_tick)  raster <= '0;
      else if (line_tick)   raster <= (raster == LAST_LINE) ? '0 : raster + 9'd1;
   end

   // Shadow copies feed the renderer; without the latch they refresh every cycle.
`ifdef VIC_FRAME_LATCH_EN
   assign load = frame_tick;
`else
   assign load = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh2 <= 8'h96; sh3 <= 7'h2E; sh5 <= 8'hF0; she <= 4'h0; shf <= 8'h1B;
      end else if (load) begin
         sh2 <= r2; sh3 <= r3; sh5 <= r5; she <= re[7:4]; shf <= rf;
      end
   end

   // VIC 14-bit address space maps to CPU space with bit 13 inverted.
   assign scr_v          = {sh5[7:4], sh2[7], 9'b0};
   assign chr_v          = {sh5[3:0], 10'b0};
   assign screen_addr    = {~scr_v[13], 2'b00, scr_v[12:0]};
   assign char_rom_addr  = {~chr_v[13], 2'b00, chr_v[12:0]};
   assign color_ram_addr = sh2[7] ? 16'h9600 : 16'h9400;
   assign border_color   = shf[2:0];
   assign inverted       = shf[3];
   assign back_color     = shf[7:4];
   assign aux_color      = she;
   assign chars8x16      = sh3[0];
   assign rows           = {1'b0, sh3[6:1]};
   assign cols           = sh2[6:0];

endmodule

// File: tb/tb_vic_regs.sv
// Randomized self-checking bench for vic_regs against a behavioural register model.
module tb_vic_regs;
   localparam int LINES = 312;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_cs = 1'b0, cpu_we = 1'b0, line_tick = 1'b0, frame_tick = 1'b0;
   logic [3:0]  cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic [7:0]  cpu_dout;
   logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
   logic [2:0]  border_color;
   logic [3:0]  back_color, aux_color;
   logic        inverted, chars8x16;
   logic [6:0]  rows, cols;
   logic [8:0]  raster;

   vic_regs #(.RASTER_LINES(LINES)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .line_tick(line_tick), .frame_tick(frame_tick),
      .screen_addr(screen_addr), .char_rom_addr(char_rom_addr),
      .color_ram_addr(color_ram_addr), .border_color(border_color),
      .back_color(back_color), .inverted(inverted), .aux_color(aux_color),
      .chars8x16(chars8x16), .rows(rows), .cols(cols), .raster(raster));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   bit run = 1'b0;

   // model: live register bytes, the copy the renderer sees, raster, read data
   logic [7:0] m [16];
   logic [7:0] vis [16];
   int         m_raster;
   logic [7:0] m_dout;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      m[0] = 8'h0C; m[1] = 8'h26; m[2] = 8'h96; m[3] = 8'h2E; m[5] = 8'hF0; m[15] = 8'h1B;
      for (int i = 0; i < 16; i++) vis[i] = m[i];
      m_raster = 0;
      m_dout = 8'h00;
   endtask

   function automatic logic [7:0] model_read(input int a);
      case (a)
         3:       return {m_raster[0], m[3][6:0]};
         4:       return 8'(m_raster / 2);
         6, 7:    return 8'h00;
         8, 9:    return 8'hFF;
         default: return m[a];
      endcase
   endfunction

   function automatic logic [15:0] to_cpu(input int v);
      return (v < 8192) ? 16'(v + 32'h8000) : 16'(v - 8192);
   endfunction

   // Applied at each rising edge, using the values in force just before it.
   task automatic model_step();
      int a;
      bit latch;
      a = int'(cpu_addr);
      if (cpu_cs && !cpu_we) m_dout = model_read(a);
`ifdef VIC_FRAME_LATCH_EN
      latch = frame_tick;
`else
      latch = 1'b1;
`endif
      if (latch) for (int i = 0; i < 16; i++) vis[i] = m[i];
      if (cpu_cs && cpu_we && !(a inside {4, 6, 7, 8, 9})) m[a] = cpu_din;
      if (frame_tick)     m_raster = 0;
      else if (line_tick) m_raster = (m_raster + 1) % LINES;
   endtask

   task automatic tick(input bit cs, input bit we, input int a, input int d,
                       input bit lt, input bit ft);
      cpu_cs = cs; cpu_we = we; cpu_addr = 4'(a); cpu_din = 8'(d);
      line_tick = lt; frame_tick = ft;
      @(posedge clk);
      model_step();
      @(negedge clk);
      cpu_cs = 1'b0; cpu_we = 1'b0; line_tick = 1'b0; frame_tick = 1'b0;
   endtask

   always @(negedge clk) if (run) begin
      chk("cpu_dout", cpu_dout, m_dout);
      chk("raster", raster, m_raster);
      chk("screen_addr", screen_addr, to_cpu(vis[5][7:4] * 1024 + vis[2][7] * 512));
      chk("char_rom_addr", char_rom_addr, to_cpu(vis[5][3:0] * 1024));
      chk("color_ram_addr", color_ram_addr, vis[2][7] ? 16'h9600 : 16'h9400);
      chk("border_color", border_color, vis[15] % 8);
      chk("inverted", inverted, (vis[15] / 8) % 2);
      chk("back_color", back_color, vis[15] / 16);
      chk("aux_color", aux_color, vis[14] / 16);
      chk("chars8x16", chars8x16, vis[3] % 2);
      chk("rows", rows, (vis[3] % 128) / 2);
      chk("cols", cols, vis[2] % 128);
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run = 1'b1;
      #1;
      chk("rst screen", screen_addr, 16'h1E00);
      chk("rst chars", char_rom_addr, 16'h8000);
      chk("rst color", color_ram_addr, 16'h9600);
      chk("rst cols", cols, 7'd22);
      chk("rst rows", rows, 7'd23);
      chk("rst border", {back_color, inverted, border_color}, {4'd1, 1'b1, 3'd3});
      chk("rst dout", cpu_dout, 8'h00);

      // base decode
      tick(1, 1, 5, 8'hC2, 0, 0);
      tick(1, 1, 2, 8'h16, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      #1;
      chk("dec screen", screen_addr, 16'h1000);
      chk("dec chars", char_rom_addr, 16'h8800);
      chk("dec color", color_ram_addr, 16'h9400);
      chk("dec cols", cols, 7'd22);

      // readback
      tick(1, 1, 3, 8'h2F, 0, 0);
      tick(1, 0, 3, 0, 0, 0);  #1 chk("rd reg3", cpu_dout, 8'h2F);
      tick(1, 0, 6, 0, 0, 0);  #1 chk("rd reg6", cpu_dout, 8'h00);
      tick(1, 0, 8, 0, 0, 0);  #1 chk("rd reg8", cpu_dout, 8'hFF);
      tick(1, 0, 15, 0, 0, 0); #1 chk("rd regF", cpu_dout, 8'h1B);
      tick(0, 0, 0, 0, 0, 0);  #1 chk("dout hold", cpu_dout, 8'h1B);

      // raster counting and wrap
      tick(0, 0, 0, 0, 1, 1);
      repeat (301) tick(0, 0, 0, 0, 1, 0);
      #1 chk("raster 301", raster, 9'd301);
      tick(1, 0, 4, 0, 0, 0); #1 chk("rd reg4", cpu_dout, 8'h96);
      tick(1, 0, 3, 0, 0, 0); #1 chk("rd reg3 odd", cpu_dout, 8'hAF);
      repeat (11) tick(0, 0, 0, 0, 1, 0);
      #1 chk("raster wrap", raster, 9'd0);
      repeat (3) tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 1);
      #1 chk("raster both", raster, 9'd0);

`ifdef VIC_FRAME_LATCH_EN
      tick(1, 1, 15, 8'h08, 0, 0);
      repeat (3) tick(0, 0, 0, 0, 1, 0);
      #1 chk("latch hold", border_color, 3'd3);
      tick(0, 0, 0, 0, 0, 1);
      #1 chk("latch load", {back_color, border_color}, 7'd0);
      tick(1, 1, 15, 8'h1B, 0, 1);
      tick(0, 0, 0, 0, 0, 0);
      #1 chk("latch skip", border_color, 3'd0);
      tick(0, 0, 0, 0, 0, 1);
      #1 chk("latch next", border_color, 3'd3);
`else
      tick(1, 1, 15, 8'h08, 0, 0);
      #1 chk("wr not yet", border_color, 3'd3);
      tick(0, 0, 0, 0, 0, 0);
      #1 chk("wr visible", {back_color, border_color}, 7'd0);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++)
         tick($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(15, 0),
              $urandom_range(255, 0), $urandom_range(9, 0) < 3, $urandom_range(199, 0) == 0);

      // async reset in the middle of a read
      tick(1, 1, 15, 8'h55, 1, 0);
      tick(1, 0, 15, 0, 1, 0);
      #1 chk("pre-rst dout", cpu_dout, 8'h55);
      cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hF;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("arst dout", cpu_dout, 8'h00);
      chk("arst raster", raster, 9'd0);
      chk("arst screen", screen_addr, 16'h1E00);
      chk("arst border", border_color, 3'd3);
      cpu_cs = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      repeat (3) tick(0, 0, 0, 0, 1, 0);
      #1 chk("no stale dout", cpu_dout, 8'h00);
      tick(1, 0, 15, 0, 0, 0); #1 chk("post-rst regF", cpu_dout, 8'h1B);
      for (int n = 0; n < 500; n++)
         tick($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(15, 0),
              $urandom_range(255, 0), $urandom_range(9, 0) < 4, $urandom_range(99, 0) == 0);

      run = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/vic_regs.md
# vic_regs

CPU-facing register file of the VIC-20 video subsystem, modelled on the 6560/6561 register map at CPU $9000–$900F. It holds the 16 VIC registers and maintains the raster line counter for readback. It decodes screen, character and colour base addresses into CPU-space addresses, and drives the configuration inputs of the downstream `video` renderer (`screen_addr`, `char_rom_addr`, `color_ram_addr`, colours, `rows`, `cols`, mode bits).

## Interface
- `RASTER_LINES`, 312: raster lines per frame (312 PAL, 261 NTSC); counter wraps after `RASTER_LINES-1`.
- `clk`  in  1  system clock; the only clock, also used by `video`.
- `reset_n`  in  1  asynchronous active-low reset.
- `cpu_cs`  in  1  register select, asserted for CPU accesses to $9000–$900F.
- `cpu_we`  in  1  1 = write, 0 = read; sampled with `cpu_cs`.
- `cpu_addr`  in  4  register index 0–15.
- `cpu_din`  in  8  write data.
- `cpu_dout`  out  8  registered read data.
- `line_tick`  in  1  one-cycle pulse per raster line.
- `frame_tick`  in  1  one-cycle pulse at start of frame.
- `screen_addr`  out  16  CPU address of screen matrix.
- `char_rom_addr`  out  16  CPU address of character generator.
- `color_ram_addr`  out  16  $9400 or $9600.
- `border_color`  out  3  reg $F[2:0].
- `back_color`  out  4  reg $F[7:4].
- `inverted`  out  1  reg $F[3]; 1 = normal video, 0 = reverse.
- `aux_color`  out  4  reg $E[7:4].
- `chars8x16`  out  1  reg $3[0].
- `rows`  out  7  {1'b0, reg $3[6:1]}.
- `cols`  out  7  reg $2[6:0].
- `raster`  out  9  current raster line.

## Operation
- Storage: reg0–reg5 and regA–regF are read/write bytes. Reg3 bit7 and reg4 are not stored; they read back the raster counter. Reg6/7 (light pen) read $00 and ignore writes. Reg8/9 (paddles) read $FF and ignore writes.
- Reset values: reg0=$0C, reg1=$26, reg2=$96, reg3[6:0]=$2E, reg5=$F0, regA–regD=$00, regE=$00, regF=$1B; raster=0; `cpu_dout`=$00.
- Resulting output reset values: `screen_addr`=$1E00, `char_rom_addr`=$8000, `color_ram_addr`=$9600, `cols`=22, `rows`=23, `chars8x16`=0, `border_color`=3, `back_color`=1, `inverted`=1, `aux_color`=0.
- Address decode: form the 14-bit VIC address v, then map it to CPU space as {~v[13], 2'b00, v[12:0]}. VIC $0000–$1FFF maps to CPU $8000–$9FFF; VIC $2000–$3FFF maps to CPU $0000–$1FFF.
  - Screen: v = {reg5[7:4], reg2[7], 9'b0}.
  - Characters: v = {reg5[3:0], 10'b0}.
  - `color_ram_addr` = reg2[7] ? $9600 : $9400.
- Write: when `cpu_cs && cpu_we` at a clk edge, the addressed register takes `cpu_din` at that edge.
- Read: when `cpu_cs && !cpu_we`, `cpu_dout` loads the addressed value at that edge. Reg3 reads as {raster[0], reg3[6:0]}; reg4 reads as raster[8:1]. `cpu_dout` holds its value when not reading.
- Raster counter:
  - `frame_tick` forces it to 0.
  - Otherwise `line_tick` increments it, wrapping from `RASTER_LINES-1` to 0.
  - When both ticks are high in the same cycle, `frame_tick` wins and the counter becomes 0.

## Timing
- Register write: visible to reads starting with a read issued on the next cycle.
- Read latency: 1 cycle, with `cpu_dout` valid after the sampling edge. A read of reg3/reg4 returns the raster value as it was before that edge's tick update.
- Output update is registered:
  - Without the macro, outputs reflect a write one cycle after the write edge.
  - With the macro, see Configuration.
- Asynchronous reset assertion at any time, including mid-frame or mid-access, immediately restores all reset values. The first edge after `reset_n` rises is a normal cycle.

## Configuration
- `VIC_FRAME_LATCH_EN` defined:
  - All renderer-facing outputs come from shadow registers, loaded from the live registers only on cycles with `frame_tick`=1. This prevents mid-frame tearing.
  - A write coinciding with `frame_tick` is not captured; it appears at the following `frame_tick`.
  - Shadows reset to the same values as the live registers.
  - `raster` and `cpu_dout` are unaffected.
- Not defined: no shadow registers; outputs track the live registers with 1-cycle latency.

## Test plan
- Reset: pulse `reset_n` low mid-frame → `screen_addr`=$1E00, `char_rom_addr`=$8000, `color_ram_addr`=$9600, `cols`=22, `rows`=23, `border_color`=3, `back_color`=1, raster=0.
- Base decode: write reg5=$C2, reg2=$16 → `screen_addr`=$1000, `char_rom_addr`=$8800, `color_ram_addr`=$9400, `cols`=22.
- Readback: write reg3=$2F, read reg3 → $2F with raster even; read reg6 → $00, reg8 → $FF, regF → $1B.
- Raster: 301 `line_tick` pulses after `frame_tick` → raster=301, reg4 reads $96, reg3 bit7=1; with `RASTER_LINES`=312, 312 pulses wrap to 0; simultaneous `frame_tick`+`line_tick` → 0.
- Frame latch (`VIC_FRAME_LATCH_EN`): write regF=$08 → `border_color` stays 3 until the next `frame_tick`, then `border_color`=0, `back_color`=0; a write on the `frame_tick` cycle appears only one frame later.
- Async reset during read access → `cpu_dout`=$00 immediately, no stale data afterwards.
